// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared state encoding and constants for the memory bridge
package mem_bridge_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic CH_I = 1'b0;
    localparam logic CH_D = 1'b1;
    localparam logic [1:0] KSEG_HI = 2'b10;
endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if: instruction/data channels plus the shared memory bus
interface mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [DATA_W/8-1:0] i_wstrb;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_stall;
    logic              d_req;
    logic [DATA_W/8-1:0] d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;
    logic              bus_req;
    logic              bus_wr;
    logic [DATA_W/8-1:0] bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  i_req, i_wstrb, i_addr, i_wdata,
        output i_rdata, i_done, i_stall,
        input  d_req, d_wstrb, d_addr, d_wdata,
        output d_rdata, d_done, d_stall,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output i_req, i_wstrb, i_addr, i_wdata,
        input  i_rdata, i_done, i_stall,
        output d_req, d_wstrb, d_addr, d_wdata,
        input  d_rdata, d_done, d_stall,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bridge_addr_map.sv
// mem_addr_map: kseg0/kseg1 virtual-to-physical mapping, other segments pass through
module mem_addr_map
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] phys
);
    always_comb phys = (MAP_KSEG && addr[ADDR_W-1 -: 2] == KSEG_HI) ? {3'b000, addr[ADDR_W-4:0]} : addr;
endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: arbitrates instruction/data channels onto one handshaked memory bus
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit MAP_KSEG = 1'b1,
    parameter bit DATA_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    mem_bridge_if.master mb
);
    localparam int SW = DATA_W / 8;

    state_t state, state_nx;
    logic pend_i, pend_d, grant_d, latch, finish, owner;
    logic i_done_q, d_done_q;
    logic [SW-1:0] wstrb_q;
    logic [ADDR_W-1:0] addr_q, sel_addr, map_addr;
    logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

    // a channel whose done is pulsing this cycle is not a new request yet
    assign pend_i = mb.i_req & ~i_done_q;
    assign pend_d = mb.d_req & ~d_done_q;
    assign grant_d = pend_d & (DATA_FIRST | ~pend_i);
    assign sel_addr = grant_d ? mb.d_addr : mb.i_addr;
    assign latch = state == IDLE && (pend_i || pend_d);
    assign finish = state == DATA && mb.bus_data_ok;

    mem_addr_map #(.ADDR_W(ADDR_W), .MAP_KSEG(MAP_KSEG)) u_map (
        .addr(sel_addr),
        .phys(map_addr)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = latch ? ADDR
                 : (state == ADDR && mb.bus_addr_ok) ? DATA
                 : finish ? IDLE
                 : state;
    end

    always_comb begin
        mb.bus_req   = state == ADDR;
        mb.bus_wr    = |wstrb_q;
        mb.bus_wstrb = wstrb_q;
        mb.bus_addr  = addr_q;
        mb.bus_wdata = wdata_q;
        mb.i_rdata   = i_rdata_q;
        mb.d_rdata   = d_rdata_q;
        mb.i_done    = i_done_q;
        mb.d_done    = d_done_q;
        mb.i_stall   = pend_i;
        mb.d_stall   = pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= CH_I;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            i_done_q <= finish && owner == CH_I;
            d_done_q <= finish && owner == CH_D;
            if (latch) begin
                owner   <= grant_d;
                wstrb_q <= grant_d ? mb.d_wstrb : mb.i_wstrb;
                addr_q  <= map_addr;
                wdata_q <= grant_d ? mb.d_wdata : mb.i_wdata;
            end
            if (finish && ~|wstrb_q && owner == CH_I) i_rdata_q <= mb.bus_rdata;
            if (finish && ~|wstrb_q && owner == CH_D) d_rdata_q <= mb.bus_rdata;
        end
    end
endmodule

// File: doc/mem_bridge.md
# mem_bridge

Parametrised memory bridge between the pipeline's instruction and data ports and a single shared handshaked memory bus (req / addr_ok / data_ok). It replaces the fixed single-cycle SRAM wiring at the CPU top. It adds four things the direct wiring does not have:
- arbitration of two channels onto one bus
- multi-cycle latency with stall generation
- configurable kseg0/kseg1 address mapping
- registered response capture

It sits between the datapath's fetch/memory stages and the external memory (or cache) bus.

## Interface
Parameters:
- ADDR_W, 32, address width of channels and bus (≥ 30)
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAP_KSEG, 1, 1 = map 0x8000_0000–0xBFFF_FFFF to physical by clearing addr[ADDR_W-1:ADDR_W-3]; 0 = pass through
- DATA_FIRST, 1, 1 = data channel wins simultaneous requests; 0 = instruction channel wins

Ports (x ∈ {i, d}):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- x_req  in  1  channel request; held high with stable fields until x_done
- x_wstrb  in  DATA_W/8  byte write strobes; 0 = read (i_wstrb tied 0 by user)
- x_addr  in  ADDR_W  virtual address
- x_wdata  in  DATA_W  write data
- x_rdata  out  DATA_W  registered read data of last completed read on channel x
- x_done  out  1  one-cycle completion pulse
- x_stall  out  1  x_req & ~x_done, combinational
- bus_req  out  1  bus request
- bus_wr  out  1  |wstrb of latched transaction
- bus_wstrb  out  DATA_W/8  latched strobes
- bus_addr  out  ADDR_W  mapped physical address
- bus_wdata  out  DATA_W  latched write data
- bus_addr_ok  in  1  address accepted this cycle
- bus_data_ok  in  1  data phase complete this cycle
- bus_rdata  in  DATA_W  valid when bus_data_ok

## Operation
The bridge handles one outstanding transaction at a time. Its FSM has three states:

- **IDLE**
  - If any x_req is high and that channel's x_done is not high this cycle, pick the winner (DATA_FIRST rule).
  - Latch the winner's wstrb, mapped addr and wdata, plus the owner id.
  - Go to ADDR.
- **ADDR**
  - bus_req = 1 and the latched fields are driven.
  - On bus_addr_ok, go to DATA.
  - bus_data_ok is ignored in ADDR; the bus never returns data_ok before the cycle after addr_ok.
- **DATA**
  - bus_req = 0.
  - On bus_data_ok:
    - For a read, register bus_rdata into the owner's x_rdata.
    - Pulse the owner's x_done next cycle.
    - Go to IDLE.

Rules:
- Once latched, a transaction always completes on the bus. A channel that drops x_req mid-flight still receives its x_done pulse and rdata update; the core discards them.
- The losing channel stays pending and is served at the next IDLE. There is no starvation because every transaction is finite.
- Mapping (MAP_KSEG = 1): addr[ADDR_W-1:ADDR_W-2] == 2'b10 → top 3 bits cleared. All other addresses (kuseg, kseg2/3) pass unchanged.
- x_rdata is not changed by writes or by the other channel's completions.

## Timing
- Reset:
  - state = IDLE
  - bus_req = 0, bus_wr = 0, bus_wstrb = 0, bus_addr = 0, bus_wdata = 0
  - i_rdata = 0, d_rdata = 0, i_done = 0, d_done = 0
- Minimum latency with a zero-wait bus:
  - Req seen in IDLE at cycle 0.
  - bus_req at cycle 1, addr_ok at cycle 1.
  - data_ok at cycle 2.
  - x_done at cycle 3.
  - This gives 3 cycles req→done.
- Back-to-back: the cycle x_done pulses, the FSM is in IDLE and can latch the other channel's pending request. The same channel's next request is seen the cycle after its x_done.
- addr_ok held low for N cycles: bus_req stays high with all fields stable for N cycles.
- rst asserted mid-transaction: the FSM returns to IDLE the next cycle and no x_done is issued. The bus slave shares rst.

## Structure
- Package mem_bridge_pkg holds:
  - state enum {IDLE, ADDR, DATA}
  - owner id constants CH_I = 0, CH_D = 1
  - KSEG_HI = 2'b10 constant
- Sub-module mem_addr_map: combinational kseg mapper, parametrised by ADDR_W and MAP_KSEG. It is instanced once on the arbiter-selected address before the latch.

## Test plan
- Single read: d_req, d_addr = 0x8000_1000, d_wstrb = 0, with bus_rdata = 0xDEADBEEF at data_ok → bus_addr = 0x0000_1000, bus_wr = 0, d_done at cycle 3, d_rdata = 0xDEADBEEF.
- Simultaneous requests:
  - i_addr = 0xBFC0_0000 and d_addr = 0x0000_0040 in the same cycle, DATA_FIRST = 1 → d served first, then i with bus_addr = 0x1FC0_0000.
  - With DATA_FIRST = 0, the order is reversed.
- Wait states: addr_ok delayed 4 cycles and data_ok delayed 3 cycles → bus_req high for exactly 5 cycles with stable fields, x_stall high throughout, x_done 1 cycle only.
- Write: d_wstrb = 4'b0011, d_wdata = 0x1234_5678, d_addr = 0x1000_0008 → bus_wr = 1, bus_addr unchanged (MAP_KSEG maps only the 2'b10 region), d_rdata unchanged after d_done.
- Abort and reset:
  - i_req dropped after addr_ok → i_done still pulses and i_rdata updates.
  - rst pulsed in DATA → all outputs 0 next cycle, no done, and a fresh request afterwards completes normally.
